// File: rtl/multicycle_addsub.sv
// Multi-cycle add/subtract: CHUNK-bit adder slice iterated LSB-first with a rippled carry.
// Latency: done is high NCH = WIDTH/CHUNK cycles after the accepting edge; back-to-back without a gap.
// Backpressure: none; start is taken only in IDLE/DONE, and starts seen while busy are dropped.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            request; op_sub/a/b/cin are captured when it is accepted
//   op_sub           0: a+b+cin, 1: a-b-cin (cin is a borrow-in)
//   busy, done       busy is high in BUSY; done is a one-cycle pulse at result commit
//   sum              {carry-out or borrow-out, WIDTH-bit result}
//   ovf, zero        signed overflow of the WIDTH-bit result; result equals zero
module multicycle_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum,
  output logic             ovf,
  output logic             zero
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH + 1) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCH - 1);
  localparam logic [KW-1:0] KSAT  = KW'(NCH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb, partial, partial_nxt;
  logic             carry, op_sub_r;
  logic [KW-1:0]    k;
  logic [CHUNK-1:0] sl_a, sl_b, sl_s;
  logic             sl_cout, sl_cmsb;
  logic             accept, last;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (state == BUSY) && (k == KLAST);

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (k == KLAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? BUSY : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Adder slice on chunk k. Subtraction arrives here already as a + ~b + ~cin.
  always_comb begin
    sl_a        = '0;
    sl_b        = '0;
    partial_nxt = partial;
    for (int i = 0; i < NCH; i++) begin
      if (k == KW'(i)) begin
        sl_a = opa[i*CHUNK +: CHUNK];
        sl_b = opb[i*CHUNK +: CHUNK];
      end
    end
    {sl_cout, sl_s} = {1'b0, sl_a} + {1'b0, sl_b} + {{CHUNK{1'b0}}, carry};
    // Carry into the slice MSB, recovered from the MSB sum bit; valid for any CHUNK >= 1.
    sl_cmsb = sl_s[CHUNK-1] ^ sl_a[CHUNK-1] ^ sl_b[CHUNK-1];
    for (int i = 0; i < NCH; i++) begin
      if (k == KW'(i)) partial_nxt[i*CHUNK +: CHUNK] = sl_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      opa      <= '0;
      opb      <= '0;
      partial  <= '0;
      carry    <= 1'b0;
      op_sub_r <= 1'b0;
      k        <= '0;
      sum      <= '0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        opa      <= a;
        opb      <= op_sub ? ~b : b;
        carry    <= op_sub ? ~cin : cin;
        op_sub_r <= op_sub;
        k        <= '0;
        partial  <= '0;
      end else if (state == BUSY) begin
        partial <= partial_nxt;
        carry   <= sl_cout;
        if (k != KSAT) k <= k + KW'(1);
        // Outputs move only here, so intermediate chunks never show on sum.
        if (last) begin
          sum  <= {op_sub_r ? ~sl_cout : sl_cout, partial_nxt};
          ovf  <= sl_cmsb ^ sl_cout;
          zero <= (partial_nxt == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_multicycle_addsub.sv
module tb_multicycle_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [2:0]       start, op_sub, cin;
  logic [2:0][15:0] a_v, b_v;

  logic busy0, busy1, busy2, done0, done1, done2;
  logic ovf0, ovf1, ovf2, zero0, zero1, zero2;
  logic [8:0]  sum0, sum1;
  logic [16:0] sum2;

  int nvec = 0;
  int nerr = 0;

  // sel 0: WIDTH=8 CHUNK=4, sel 1: WIDTH=8 CHUNK=8, sel 2: WIDTH=16 CHUNK=4
  multicycle_addsub #(.WIDTH(8), .CHUNK(4)) u_w8c4 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .op_sub(op_sub[0]),
    .a(a_v[0][7:0]), .b(b_v[0][7:0]), .cin(cin[0]),
    .busy(busy0), .done(done0), .sum(sum0), .ovf(ovf0), .zero(zero0));

  multicycle_addsub #(.WIDTH(8), .CHUNK(8)) u_w8c8 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .op_sub(op_sub[1]),
    .a(a_v[1][7:0]), .b(b_v[1][7:0]), .cin(cin[1]),
    .busy(busy1), .done(done1), .sum(sum1), .ovf(ovf1), .zero(zero1));

  multicycle_addsub #(.WIDTH(16), .CHUNK(4)) u_w16c4 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .op_sub(op_sub[2]),
    .a(a_v[2]), .b(b_v[2]), .cin(cin[2]),
    .busy(busy2), .done(done2), .sum(sum2), .ovf(ovf2), .zero(zero2));

  function automatic logic get_busy(input int sel);
    case (sel) 0: return busy0; 1: return busy1; default: return busy2; endcase
  endfunction
  function automatic logic get_done(input int sel);
    case (sel) 0: return done0; 1: return done1; default: return done2; endcase
  endfunction
  function automatic logic get_ovf(input int sel);
    case (sel) 0: return ovf0; 1: return ovf1; default: return ovf2; endcase
  endfunction
  function automatic logic get_zero(input int sel);
    case (sel) 0: return zero0; 1: return zero1; default: return zero2; endcase
  endfunction
  function automatic logic [16:0] get_sum(input int sel);
    case (sel) 0: return {8'h00, sum0}; 1: return {8'h00, sum1}; default: return sum2; endcase
  endfunction
  function automatic int width_of(input int sel);
    return (sel == 2) ? 16 : 8;
  endfunction
  function automatic int nch_of(input int sel);
    case (sel) 0: return 2; 1: return 1; default: return 4; endcase
  endfunction

  // Reference: integer arithmetic on the operands, no knowledge of chunking.
  function automatic void model(input int w, input bit op, input longint av, input longint bv,
                                input bit ci, output logic [16:0] es, output bit eo, output bit ez);
    longint half, full, sa, sb, sr;
    half = longint'(1) << (w - 1);
    full = op ? (av - bv - ci) : (av + bv + ci);
    es   = 17'(full & ((longint'(1) << (w + 1)) - 1));
    sa   = (av >= half) ? av - 2 * half : av;
    sb   = (bv >= half) ? bv - 2 * half : bv;
    sr   = op ? (sa - sb - ci) : (sa + sb + ci);
    eo   = (sr >= half) || (sr < -half);
    ez   = ((full & (2 * half - 1)) == 0);
  endfunction

  task automatic set_in(input int sel, input bit s, input bit op, input logic [15:0] av,
                        input logic [15:0] bv, input bit ci);
    start[sel]  = s;
    op_sub[sel] = op;
    a_v[sel]    = av;
    b_v[sel]    = bv;
    cin[sel]    = ci;
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_op(input int sel, input bit op, input longint av_i, input longint bv_i,
                        input bit ci, input bit poke);
    int w, nch, lat;
    longint av, bv, mask;
    logic [16:0] es, prev;
    bit eo, ez;
    w    = width_of(sel);
    nch  = nch_of(sel);
    mask = (longint'(1) << w) - 1;
    av   = av_i & mask;
    bv   = bv_i & mask;
    model(w, op, av, bv, ci, es, eo, ez);
    prev = get_sum(sel);
    set_in(sel, 1'b1, op, 16'(av), 16'(bv), ci);
    @(negedge clk);
    // Operand churn (and optionally a stray start) during BUSY must not matter.
    set_in(sel, poke, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
    nvec++;
    if (get_busy(sel) !== 1'b1 || get_done(sel) !== 1'b0) begin
      nerr++;
      $display("FAIL busy_after_start sel=%0d busy=%b done=%b want busy=1 done=0",
               sel, get_busy(sel), get_done(sel));
    end
    lat = 0;
    while (get_done(sel) !== 1'b1 && lat < 20) begin
      nvec++;
      if (get_sum(sel) !== prev) begin
        nerr++;
        $display("FAIL sum_held sel=%0d got=%h want=%h", sel, get_sum(sel), prev);
      end
      @(negedge clk);
      lat++;
      set_in(sel, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
    end
    nvec++;
    if (lat != nch) begin
      nerr++;
      $display("FAIL latency sel=%0d got=%0d want=%0d", sel, lat, nch);
    end
    nvec++;
    if (get_sum(sel) !== es || get_ovf(sel) !== eo || get_zero(sel) !== ez || get_busy(sel) !== 1'b0) begin
      nerr++;
      $display("FAIL result sel=%0d op=%0d a=%h b=%h cin=%0d got sum=%h ovf=%b zero=%b busy=%b want sum=%h ovf=%b zero=%b busy=0",
               sel, op, av, bv, ci, get_sum(sel), get_ovf(sel), get_zero(sel), get_busy(sel), es, eo, ez);
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int s = 0; s < 3; s++) begin
      nvec++;
      if (get_busy(s) !== 1'b0 || get_done(s) !== 1'b0 || get_sum(s) !== 17'h0 ||
          get_ovf(s) !== 1'b0 || get_zero(s) !== 1'b0) begin
        nerr++;
        $display("FAIL %s sel=%0d got busy=%b done=%b sum=%h ovf=%b zero=%b want all 0",
                 name, s, get_busy(s), get_done(s), get_sum(s), get_ovf(s), get_zero(s));
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) set_in(s, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    #2;
    check_all_zero("reset_state");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("after_reset_idle");
  endtask

  task automatic test_directed;
    run_op(0, 1'b0, 'hC8, 'h64, 1'b0, 1'b0);
    @(negedge clk);
    run_op(0, 1'b1, 'h05, 'h07, 1'b0, 1'b0);
    @(negedge clk);
    run_op(0, 1'b0, 'h7F, 'h01, 1'b0, 1'b0);
    @(negedge clk);
    run_op(0, 1'b1, 'h80, 'h80, 1'b0, 1'b0);
    @(negedge clk);
    run_op(0, 1'b0, 'hFF, 'h00, 1'b1, 1'b0);
    @(negedge clk);
    run_op(0, 1'b1, 'h00, 'h00, 1'b1, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_params;
    run_op(1, 1'b0, 'hC8, 'h64, 1'b0, 1'b0);
    @(negedge clk);
    run_op(1, 1'b1, 'h80, 'h01, 1'b0, 1'b0);
    @(negedge clk);
    run_op(2, 1'b0, 'hFFFF, 'h0001, 1'b0, 1'b0);
    @(negedge clk);
    run_op(2, 1'b1, 'h8000, 'h0001, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_busy_ignored;
    for (int s = 0; s < 3; s++) begin
      run_op(s, 1'b0, 'h1234, 'h0F0F, 1'b1, 1'b1);
      @(negedge clk);
      nvec++;
      if (get_done(s) !== 1'b0 || get_busy(s) !== 1'b0) begin
        nerr++;
        $display("FAIL single_done sel=%0d got done=%b busy=%b want 0 0", s, get_done(s), get_busy(s));
      end
    end
  endtask

  task automatic test_back_to_back;
    run_op(0, 1'b0, 'hC8, 'h64, 1'b0, 1'b0);
    run_op(0, 1'b1, 'h05, 'h07, 1'b1, 1'b0);
    run_op(0, 1'b0, 'h7F, 'h7F, 1'b1, 1'b0);
    run_op(2, 1'b1, 'h0000, 'h0001, 1'b0, 1'b0);
    run_op(2, 1'b0, 'h7FFF, 'h0000, 1'b1, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_random;
    for (int n = 0; n < 150; n++) begin
      run_op(int'($urandom_range(0, 2)), 1'($urandom), longint'($urandom), longint'($urandom),
             1'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midbusy;
    run_op(0, 1'b0, 'hC8, 'h64, 1'b0, 1'b0);
    set_in(0, 1'b1, 1'b0, 16'h0011, 16'h0022, 1'b0);
    @(negedge clk);
    set_in(0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_midbusy");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_all_zero("reset_hold");
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_all_zero("no_done_after_abort");
    end
    run_op(0, 1'b0, 'hC8, 'h64, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = '0;
    op_sub = '0;
    cin    = '0;
    a_v    = '0;
    b_v    = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_params();
    test_busy_ignored();
    test_back_to_back();
    test_random();
    test_reset_midbusy();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
